srrc_coef_loader: RTL
=====================

// Module: srrc_coef_loader
// PURPOSE
//  Streams SRRC frequency-domain coefficients in one word per beat over a valid/ready port.
//  Writes them into a shadow bank and swaps that bank atomically into the active bank on commit.
//  Drives the packed coefficient bus H of the parallel SRRC filter directly upstream.
//  The filter never sees a partially loaded coefficient set.
// PARAMETERS
//  N   16  number of parallel coefficients (bins); must be even, >= 2
//  W   16  coefficient width, signed two's complement
// PORTS
//  clk         in   1     clock, all logic on rising edge
//  reset       in   1     asynchronous, active-high reset
//  load_start  in   1     pulse: begin (or restart) loading a coefficient set
//  coef_in     in   W     coefficient word
//  coef_valid  in   1     coef_in valid
//  coef_ready  out  1     loader accepts coef_in this cycle
//  commit      in   1     pulse: swap shadow bank into active bank
//  H           out  W*N   active coefficients; coef k at H[W*k+W-1:W*k]
//  H_valid     out  1     active bank holds a committed set
//  busy        out  1     state != IDLE
//  cmd_err     out  1     1-cycle pulse on an illegal command
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, both banks 0, H=0, H_valid=0, coef_ready=0, busy=0, cmd_err=0.
//   Reset is legal at any time, including mid-load; the partial shadow is discarded.
//  FSM states: IDLE, LOAD, FULL.
//   IDLE -load_start-> LOAD, idx<=0.
//   LOAD: coef_ready=1. Each beat with coef_valid&coef_ready writes shadow[idx] and increments idx.
//    The beat writing index LAST (N-1) moves to FULL.
//   LOAD -load_start-> LOAD, idx<=0. cmd_err pulses; the shadow is not cleared.
//    load_start has priority over a simultaneous beat; that beat is dropped.
//   FULL: coef_ready=0. On commit, active<=shadow and H/H_valid update on the next edge.
//    Latency is 1 cycle from the commit edge to the new H. FSM then goes to IDLE.
//   FULL -load_start-> LOAD, idx<=0 (reload before commit); the active bank is untouched.
//  commit in IDLE or LOAD: ignored, cmd_err pulses. load_start+commit in FULL: commit wins, cmd_err pulses.
//  load_start while busy in FULL with no commit: restart, no error.
//  H is register-driven and changes only on a commit edge.
//   It is stable across loads, so the filter can run continuously.
//  H_valid stays 1 after the first commit until reset.
//  idx width: clog2(N). LAST = N-1. No wrap past LAST: FULL blocks further beats.
//  coef_in stored verbatim, with no scaling or saturation.
// CONFIGURATION
//  SRRC_COEF_SYMMETRIC_EN defined:
//   Only N/2 beats are loaded and LAST = N/2-1.
//   Beat k writes shadow[k] and shadow[N-1-k] in the same cycle (even-symmetric response).
//  SRRC_COEF_SYMMETRIC_EN undefined: N beats, one write per beat, as above.
//  All other behaviour is identical in both builds.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE=2'd0, LOAD=2'd1, FULL=2'd2) and the LAST-index function of N.
//  Sub-module srrc_coef_bank: N x W register bank with a write port (addr, data, we) and a full-width parallel read.
//   Instanced twice (shadow, active); active loads all N words from shadow on commit.
//  FSM, idx counter and handshake live in the top level.
// TESTING
//  1 Reset, load_start, stream k=0..15 with coef_in=16'h0100+k, then commit.
//   Expect H[15:0]=16'h0100 and H[255:240]=16'h010F one cycle after commit, with H_valid=1.
//  2 Backpressure: toggle coef_valid randomly during a load.
//   Expect exactly 16 accepted beats, coef_ready=0 in FULL, and H unchanged until commit.
//  3 Commit in IDLE and mid-LOAD (after 5 beats): expect a cmd_err pulse and no change to H.
//   Then load_start mid-LOAD: idx restarts and the next beat lands at index 0.
//  4 Reload: commit set A, load set B, hold in FULL for 10 cycles with no commit.
//   Expect H==A. After commit, expect H==B.
//  5 Assert reset after 8 beats: expect all outputs 0 immediately (asynchronous) and state IDLE.
//   Then a full load and commit succeeds.
//  6 SRRC_COEF_SYMMETRIC_EN: 8 beats with values 1..8.
//   Expect H coefs 1,2,..,8,8,..,2,1; coef_ready drops after beat 8.

Source files
------------

// File: rtl/srrc_coef_loader_pkg.sv
// Shared definitions for the SRRC coefficient loader.
// Holds the FSM state encoding and the last-beat index as a function of N.
// Optional build macro: SRRC_COEF_SYMMETRIC_EN (half-length symmetric load).
package srrc_coef_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  // Index of the beat that completes a coefficient set.
  function automatic int last_idx(input int n);
`ifdef SRRC_COEF_SYMMETRIC_EN
    return n / 2 - 1;
`else
    return n - 1;
`endif
  endfunction

endpackage

// File: rtl/srrc_coef_bank.sv
// N x W coefficient register bank with one write port and a full-width read.
// Ports: clk/reset; we/addr/wdata single-word write (mirror also writes N-1-addr);
//        ld/ld_data parallel load of all N words; rd_data packed read, word k at [W*k +: W].
module srrc_coef_bank #(
  parameter int N  = 16,
  parameter int W  = 16,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic           mirror,
  input  logic [AW-1:0]  addr,
  input  logic [W-1:0]   wdata,
  input  logic           ld,
  input  logic [N*W-1:0] ld_data,
  output logic [N*W-1:0] rd_data
);

  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [AW-1:0] mir_addr;

  assign mir_addr = AW'(N - 1) - addr;

  // A parallel load takes precedence over a word write.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      mem_d[k] = mem_q[k];
      if (ld) begin
        mem_d[k] = ld_data[k*W +: W];
      end else if (we && ((addr == AW'(k)) || (mirror && (mir_addr == AW'(k))))) begin
        mem_d[k] = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) rd_data[k*W +: W] = mem_q[k];
  end

endmodule

// File: rtl/srrc_coef_loader.sv
// Streams SRRC coefficients into a shadow bank and swaps it atomically into the
// active bank driving H on commit; H changes only on a commit edge.
// Ports: clk, reset (async, active-high); load_start/commit command pulses;
//        coef_in/coef_valid/coef_ready beat handshake; H/H_valid active set;
//        busy (not IDLE); cmd_err one-cycle pulse on an illegal command.
// Build macro: SRRC_COEF_SYMMETRIC_EN loads N/2 beats, each written to k and N-1-k.
module srrc_coef_loader
  import srrc_coef_loader_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_start,
  input  logic [W-1:0]   coef_in,
  input  logic           coef_valid,
  output logic           coef_ready,
  input  logic           commit,
  output logic [W*N-1:0] H,
  output logic           H_valid,
  output logic           busy,
  output logic           cmd_err
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(last_idx(N));
`ifdef SRRC_COEF_SYMMETRIC_EN
  localparam logic MIRROR = 1'b1;
`else
  localparam logic MIRROR = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          coef_ready_q, coef_ready_d;
  logic          busy_q, busy_d;
  logic          cmd_err_q, cmd_err_d;
  logic          h_valid_q, h_valid_d;

  logic          beat;
  logic          sh_we;
  logic          act_ld;
  logic [N*W-1:0] shadow_rd;

  // coef_ready_q is high exactly while in LOAD.
  assign beat = coef_valid & coef_ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cmd_err_d = 1'b0;
    h_valid_d = h_valid_q;
    sh_we     = 1'b0;
    act_ld    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_err_d = commit;
        if (load_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        cmd_err_d = commit | load_start;
        // Restart wins over a simultaneous beat; the shadow keeps stale words.
        if (load_start) begin
          idx_d = '0;
        end else if (beat) begin
          sh_we = 1'b1;
          if (idx_q == LAST) begin
            state_d = FULL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (commit) begin
          act_ld    = 1'b1;
          h_valid_d = 1'b1;
          cmd_err_d = load_start;
          state_d   = IDLE;
        end else if (load_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    coef_ready_d = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      coef_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      h_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      coef_ready_q <= coef_ready_d;
      busy_q       <= busy_d;
      cmd_err_q    <= cmd_err_d;
      h_valid_q    <= h_valid_d;
    end
  end

  srrc_coef_bank #(.N(N), .W(W), .AW(IW)) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .we      (sh_we),
    .mirror  (MIRROR),
    .addr    (idx_q),
    .wdata   (coef_in),
    .ld      (1'b0),
    .ld_data ('0),
    .rd_data (shadow_rd)
  );

  srrc_coef_bank #(.N(N), .W(W), .AW(IW)) u_active (
    .clk     (clk),
    .reset   (reset),
    .we      (1'b0),
    .mirror  (1'b0),
    .addr    ('0),
    .wdata   ('0),
    .ld      (act_ld),
    .ld_data (shadow_rd),
    .rd_data (H)
  );

  assign coef_ready = coef_ready_q;
  assign busy       = busy_q;
  assign cmd_err    = cmd_err_q;
  assign H_valid    = h_valid_q;

endmodule
